// File: rtl/alarm_beep_sequencer_if.sv
// Bundle between the alarm/timekeeping logic and the beep sequencer.
// The master side raises the alarm request and carries the raw silence button;
// the slave side (the sequencer) returns the tone-generator controls and status.
interface alarm_beep_sequencer_if;
    logic       alarm_req;
    logic       silence_btn;
    logic       buzzer_on;
    logic       NoBuzz;
    logic       alarm_active;
    logic [7:0] burst_count;

    modport master (
        output alarm_req,
        output silence_btn,
        input  buzzer_on,
        input  NoBuzz,
        input  alarm_active,
        input  burst_count
    );

    modport slave (
        input  alarm_req,
        input  silence_btn,
        output buzzer_on,
        output NoBuzz,
        output alarm_active,
        output burst_count
    );
endinterface

// File: rtl/alarm_beep_sequencer.sv
// Alarm cadence sequencer: bursts of beeps separated by gaps, a longer pause
// between bursts, a debounced silence button and an auto-timeout after
// MAX_BURSTS bursts (0 = never). Outputs feed the tone generator directly.
// MAX_BURSTS is expected in 0..255 because burst_count is 8 bits wide.
module alarm_beep_sequencer #(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_HZ         = 100,
    parameter int BEEP_TICKS      = 20,
    parameter int GAP_TICKS       = 10,
    parameter int PAUSE_TICKS     = 60,
    parameter int BEEPS_PER_BURST = 3,
    parameter int MAX_BURSTS      = 30,
    parameter int DEBOUNCE_TICKS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    alarm_beep_sequencer_if.slave bus
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX_BG = (BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS;
    localparam int TMAX    = (TMAX_BG > PAUSE_TICKS) ? TMAX_BG : PAUSE_TICKS;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW      = (BEEPS_PER_BURST > 1) ? $clog2(BEEPS_PER_BURST) : 1;
    localparam int DW      = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [7:0] MAX_B = 8'(MAX_BURSTS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BEEP     = 3'd1,
        ST_GAP      = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_SILENCED = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [PW-1:0]   presc_r;
    logic            tick_s;
    logic            sync1_r;
    logic            sync2_r;
    logic            deb_level_r;
    logic [DW-1:0]   deb_cnt_r;
    logic            silence_pulse_r;
    logic            alarm_req_q_r;
    logic            req_rise_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   phase_last_s;
    logic            timer_done_s;
    logic [BW-1:0]   beep_idx_r;
    logic [BW-1:0]   beep_idx_next_s;
    logic [7:0]      burst_count_r;
    logic [7:0]      burst_next_s;
    logic [7:0]      burst_inc_s;
    logic            buzzer_on_r;
    logic            nobuzz_r;
    logic            alarm_active_r;

    assign tick_s      = (presc_r == PW'(DIV - 1));
    assign req_rise_s  = bus.alarm_req & ~alarm_req_q_r;
    assign burst_inc_s = (burst_count_r == 8'd255) ? 8'd255 : (burst_count_r + 8'd1);

    // Free-running timebase; deliberately not re-aligned on state changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Button synchroniser, tick-based debounce and press-edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r         <= 1'b0;
            sync2_r         <= 1'b0;
            deb_level_r     <= 1'b0;
            deb_cnt_r       <= '0;
            silence_pulse_r <= 1'b0;
        end else begin
            sync1_r         <= bus.silence_btn;
            sync2_r         <= sync1_r;
            silence_pulse_r <= 1'b0;
            if (tick_s) begin
                if (sync2_r != deb_level_r) begin
                    if (deb_cnt_r == DW'(DEBOUNCE_TICKS - 1)) begin
                        deb_level_r     <= sync2_r;
                        deb_cnt_r       <= '0;
                        // Only a press (0->1) silences; release is silent.
                        silence_pulse_r <= sync2_r;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DW'(1);
                    end
                end else begin
                    deb_cnt_r <= '0;
                end
            end
        end
    end

    // Request edge detector; resets to 1 so a request already high at reset release does not start an alarm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_req_q_r <= 1'b1;
        end else begin
            alarm_req_q_r <= bus.alarm_req;
        end
    end

    // Terminal timer value for the current timed phase.
    always_comb begin
        phase_last_s = '0;
        case (state_r)
            ST_BEEP:  phase_last_s = TW'(BEEP_TICKS - 1);
            ST_GAP:   phase_last_s = TW'(GAP_TICKS - 1);
            ST_PAUSE: phase_last_s = TW'(PAUSE_TICKS - 1);
            default:  phase_last_s = '0;
        endcase
    end

    assign timer_done_s = tick_s && (timer_r == phase_last_s);

    // Next-state logic: request loss beats silence, silence beats the cadence timer.
    always_comb begin
        state_next_s    = state_r;
        beep_idx_next_s = beep_idx_r;
        burst_next_s    = burst_count_r;
        case (state_r)
            ST_IDLE: begin
                if (req_rise_s) begin
                    state_next_s    = ST_BEEP;
                    beep_idx_next_s = '0;
                    burst_next_s    = 8'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BEEP: begin
                if (!bus.alarm_req) begin
                    state_next_s = ST_IDLE;
                end else if (silence_pulse_r) begin
                    state_next_s = ST_SILENCED;
                end else if (timer_done_s) begin
                    if (beep_idx_r == BW'(BEEPS_PER_BURST - 1)) begin
                        state_next_s = ST_PAUSE;
                    end else begin
                        state_next_s    = ST_GAP;
                        beep_idx_next_s = beep_idx_r + BW'(1);
                    end
                end else begin
                    state_next_s = ST_BEEP;
                end
            end
            ST_GAP: begin
                if (!bus.alarm_req) begin
                    state_next_s = ST_IDLE;
                end else if (silence_pulse_r) begin
                    state_next_s = ST_SILENCED;
                end else if (timer_done_s) begin
                    state_next_s = ST_BEEP;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            ST_PAUSE: begin
                if (!bus.alarm_req) begin
                    state_next_s = ST_IDLE;
                end else if (silence_pulse_r) begin
                    state_next_s = ST_SILENCED;
                end else if (timer_done_s) begin
                    burst_next_s = burst_inc_s;
                    if ((MAX_BURSTS != 0) && (burst_inc_s == MAX_B)) begin
                        state_next_s = ST_SILENCED;
                    end else begin
                        state_next_s    = ST_BEEP;
                        beep_idx_next_s = '0;
                    end
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_SILENCED: begin
                if (!bus.alarm_req) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SILENCED;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Phase timer: cleared on every state entry, counts ticks only in timed phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= '0;
        end else if (state_next_s != state_r) begin
            timer_r <= '0;
        end else if (tick_s && ((state_r == ST_BEEP) || (state_r == ST_GAP) || (state_r == ST_PAUSE))) begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // State register with outputs decoded from the next state so they switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            beep_idx_r     <= '0;
            burst_count_r  <= 8'd0;
            buzzer_on_r    <= 1'b0;
            nobuzz_r       <= 1'b0;
            alarm_active_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            beep_idx_r     <= beep_idx_next_s;
            burst_count_r  <= burst_next_s;
            buzzer_on_r    <= (state_next_s == ST_BEEP);
            nobuzz_r       <= (state_next_s == ST_SILENCED);
            alarm_active_r <= (state_next_s == ST_BEEP) || (state_next_s == ST_GAP) ||
                              (state_next_s == ST_PAUSE);
        end
    end

    assign bus.buzzer_on    = buzzer_on_r;
    assign bus.NoBuzz       = nobuzz_r;
    assign bus.alarm_active = alarm_active_r;
    assign bus.burst_count  = burst_count_r;

endmodule

// File: doc/alarm_beep_sequencer.md
Name: alarm_beep_sequencer

Overview:
Control stage that drives the 440 Hz tone generator's enable inputs (buzzer_on, NoBuzz) with a timed alarm cadence. The cadence is bursts of beeps separated by gaps, with a longer pause between bursts. A user silence button is synchronised and debounced in this block. An alarm request arms the block, and an auto-timeout ends the alarm after a fixed number of bursts. It sits between the alarm/timekeeping logic and the tone generator. Its outputs connect one-to-one to the tone generator's inputs.

Parameters:
CLK_HZ, 100000000, system clock frequency.
TICK_HZ, 100, internal timebase rate; one tick is 10 ms at the defaults.
BEEP_TICKS, 20, ticks per beep (tone on).
GAP_TICKS, 10, ticks of silence between beeps within a burst.
PAUSE_TICKS, 60, ticks of silence after the last beep of a burst.
BEEPS_PER_BURST, 3, number of beeps per burst (≥1).
MAX_BURSTS, 30, bursts before auto-silence; 0 means unlimited.
DEBOUNCE_TICKS, 3, consecutive ticks of stable button level required to accept a new level.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
alarm_req  in  1  level from alarm logic, synchronous to clk; high means the alarm condition is present
silence_btn  in  1  raw pushbutton, asynchronous and bouncing; high means pressed
buzzer_on  out  1  tone enable to the tone generator; high only during BEEP
NoBuzz  out  1  forced-mute to the tone generator; high only in SILENCED
alarm_active  out  1  high in BEEP, GAP or PAUSE
burst_count  out  8  number of completed bursts since the alarm started; saturates at 255

Behaviour:
- Reset (asynchronous, rst=1):
  - State is IDLE.
  - All counters are 0, and the synchroniser and debounced level are 0.
  - All outputs are 0.
- Tick:
  - Free-running prescaler counts 0..CLK_HZ/TICK_HZ-1.
  - tick is a 1-cycle pulse on the wrap.
  - The prescaler is not reset on state changes, so the first phase after entry may be short by up to 1 tick.
- Button path:
  - 2-flop synchroniser.
  - The debounced level updates only after the synchronised level has differed from it for DEBOUNCE_TICKS consecutive ticks; any disagreement-free tick clears the count.
  - silence_pulse is a 1-cycle pulse on each debounced 0→1 transition. Release produces no pulse.
- Request edge: req_rise = alarm_req & ~alarm_req_q, where alarm_req_q is a registered copy.
- Phase timer: counts ticks within a state and clears on every state entry. "Timer done" means tick & (timer == N-1) for that state's N.
- FSM states and transitions:
  - IDLE: on req_rise, go to BEEP with beep_idx=0 and burst_count=0.
  - BEEP: on timer done (N=BEEP_TICKS), go to PAUSE if beep_idx == BEEPS_PER_BURST-1, otherwise go to GAP with beep_idx+1.
  - GAP: on timer done (N=GAP_TICKS), go to BEEP.
  - PAUSE: on timer done (N=PAUSE_TICKS), increment burst_count (saturating). Then go to SILENCED if MAX_BURSTS≠0 and the new count == MAX_BURSTS; otherwise go to BEEP with beep_idx=0.
  - SILENCED: when alarm_req=0, go to IDLE.
- Priority in BEEP, GAP and PAUSE, highest first:
  1. alarm_req=0 → IDLE.
  2. silence_pulse → SILENCED.
  3. Timer transition.
- A req_rise while already active or SILENCED is ignored. A new alarm needs alarm_req to drop to IDLE and rise again.
- Outputs:
  - All outputs are registered and change on the same edge as the state register; there are no combinational paths from inputs.
  - Latency from alarm_req sampled high (rising) to buzzer_on=1 is 1 clk.
  - In IDLE, buzzer_on=0 and NoBuzz=0, and burst_count holds its last value until the next start.
- Sizing: the phase timer and beep_idx are wide enough for their parameter maxima. Their terminal compare uses ==; the counters never wrap inside a state.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (one tick every 10 clk), BEEP_TICKS=2, GAP_TICKS=1, PAUSE_TICKS=3, BEEPS_PER_BURST=3, MAX_BURSTS=2, DEBOUNCE_TICKS=2.
1. Pulse rst mid-simulation → all outputs 0 in the same cycle, with no clk edge needed. After release the block stays IDLE with alarm_req=0.
2. Raise alarm_req and hold it → buzzer_on rises 1 clk later.
   - buzzer_on pattern in ticks: on 2 / off 1 / on 2 / off 1 / on 2 / off 3, allowing ≤1 tick short on the first phase.
   - burst_count=1 after the first pause.
3. Continue scenario 2 → after the second pause, burst_count=2, NoBuzz=1, alarm_active=0, buzzer_on=0.
   - Drop alarm_req → IDLE next clk with NoBuzz=0.
   - Raise alarm_req again → the cadence restarts with burst_count=0.
4. During a BEEP, bounce silence_btn with 1-tick highs, then hold it high for ≥3 ticks.
   - The 1-tick highs cause no change.
   - After 2 stable ticks, the state goes to SILENCED within 1 clk of acceptance.
   - Releasing the button while alarm_req stays high keeps the block SILENCED.
5. Drop alarm_req in the same cycle as a silence_pulse while in GAP → IDLE (not SILENCED), with NoBuzz=0.
6. Hold alarm_req high through reset release → the block stays IDLE because there was no rising edge. Drop and re-raise alarm_req → BEEP starts.
